// File: rtl/time_of_day_counter_pkg.sv
// time_of_day_counter_pkg: field limits, digit width and board clock shared by the clock design
package time_of_day_counter_pkg;
    localparam int SEC_MAX        = 59;
    localparam int MIN_MAX        = 59;
    localparam int HR_MAX         = 23;
    localparam int BCD_W          = 4;
    localparam int CLK_HZ_DEFAULT = 50_000_000;
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping after MAX_TENS:MAX_ONES_AT_MAX_TENS
module bcd_mod_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int MAX_TENS             = 5,
    parameter int MAX_ONES_AT_MAX_TENS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             carry_out
);
    logic at_max;
    always_comb begin
        at_max    = tens == BCD_W'(MAX_TENS) && ones == BCD_W'(MAX_ONES_AT_MAX_TENS);
        carry_out = inc && at_max;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr || (inc && at_max)) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            tens <= ones == BCD_W'(9) ? tens + BCD_W'(1) : tens;
            ones <= ones == BCD_W'(9) ? '0 : ones + BCD_W'(1);
        end
    end
endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour BCD HH:MM:SS with 1 Hz prescaler, user edits and colon blink
module time_of_day_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             inc_hr,
    input  logic             inc_min,
    input  logic             clr_sec,
    output logic [BCD_W-1:0] hr_tens,
    output logic [BCD_W-1:0] hr_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             sec_tick,
    output logic             dot_blink
);
    localparam int PW = CLK_HZ > 2 ? $clog2(CLK_HZ) : 1;
    logic [PW-1:0] presc, presc_next;
    logic pending, raw, edit, apply, sec_carry, min_carry;
    always_comb begin
        raw        = run_en && presc == PW'(CLK_HZ - 1);
        edit       = inc_hr || inc_min;
        apply      = !clr_sec && !edit && (raw || pending);
        presc_next = (!run_en || clr_sec || raw) ? '0 : presc + PW'(1);
    end
    // An edit on a tick cycle owns the counters; the tick waits for the next edit-free cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            pending   <= 1'b0;
            sec_tick  <= 1'b0;
            dot_blink <= 1'b1;
        end else begin
            presc     <= presc_next;
            pending   <= !clr_sec && edit && (raw || pending);
            sec_tick  <= apply;
            dot_blink <= presc_next < PW'(CLK_HZ / 2);
        end
    end
    bcd_mod_counter #(.MAX_TENS(SEC_MAX / 10), .MAX_ONES_AT_MAX_TENS(SEC_MAX % 10)) u_sec (
        .clk(clk), .rst(rst), .inc(apply), .clr(clr_sec),
        .tens(sec_tens), .ones(sec_ones), .carry_out(sec_carry)
    );
    bcd_mod_counter #(.MAX_TENS(MIN_MAX / 10), .MAX_ONES_AT_MAX_TENS(MIN_MAX % 10)) u_min (
        .clk(clk), .rst(rst), .inc(inc_min || sec_carry), .clr(1'b0),
        .tens(min_tens), .ones(min_ones), .carry_out(min_carry)
    );
    // sec_carry only fires on an applied tick, so a minute edit at :59 never reaches hours
    bcd_mod_counter #(.MAX_TENS(HR_MAX / 10), .MAX_ONES_AT_MAX_TENS(HR_MAX % 10)) u_hr (
        .clk(clk), .rst(rst), .inc(inc_hr || (sec_carry && min_carry)), .clr(1'b0),
        .tens(hr_tens), .ones(hr_ones), .carry_out()
    );
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: scoreboard bench, stimulus queues expectations and a negedge monitor checks them
module tb_time_of_day_counter;
    logic clk = 0, rst = 1, run_en = 0, inc_hr = 0, inc_min = 0, clr_sec = 0;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic sec_tick, dot_blink;
    logic [23:0] cur;
    int checks = 0, errors = 0, ticks_seen = 0, ticks_pushed = 0;
    typedef struct {
        string       name;
        logic [23:0] t;
        logic        tick;
        logic        dot;
    } snap_t;
    snap_t snap_q[$];
    logic [23:0] tick_q[$];
    snap_t se;
    logic [23:0] te;
    always #5 clk = ~clk;
    assign cur = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
    time_of_day_counter #(.CLK_HZ(4)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec),
        .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .sec_tick(sec_tick), .dot_blink(dot_blink)
    );
    function automatic logic [23:0] tod(int h, int m, int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic snap(string name, logic [23:0] t, logic tick, logic dot);
        snap_t e;
        e.name = name; e.t = t; e.tick = tick; e.dot = dot;
        snap_q.push_back(e);
    endtask
    task automatic expect_tick(logic [23:0] t);
        tick_q.push_back(t);
        ticks_pushed++;
    endtask
    task automatic pulse_hr(int n);
        repeat (n) begin inc_hr = 1; step(1); inc_hr = 0; end
    endtask
    task automatic pulse_min(int n);
        repeat (n) begin inc_min = 1; step(1); inc_min = 0; end
    endtask
    always @(negedge clk) begin
        if (sec_tick) begin
            ticks_seen++;
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick: got sec_tick at time %h, required no tick", cur);
            end else begin
                te = tick_q.pop_front();
                if (cur !== te) begin
                    errors++;
                    $display("FAIL tick_value: got %h required %h", cur, te);
                end
            end
        end
        while (snap_q.size() > 0) begin
            se = snap_q.pop_front();
            checks++;
            if (cur !== se.t || sec_tick !== se.tick || dot_blink !== se.dot) begin
                errors++;
                $display("FAIL %s: got time=%h tick=%b dot=%b required time=%h tick=%b dot=%b",
                         se.name, cur, sec_tick, dot_blink, se.t, se.tick, se.dot);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
    initial begin
        step(2);
        snap("reset", tod(0, 0, 0), 0, 1);
        rst = 0; run_en = 1;
        for (int s = 1; s <= 61; s++) expect_tick(tod(0, s / 60, s % 60));
        for (int k = 1; k <= 244; k++) begin
            step(1);
            snap("run", tod(0, (k / 4) / 60, (k / 4) % 60), k % 4 == 0, k % 4 < 2);
        end
        @(negedge clk); #1;
        checks++;
        if (ticks_seen != 61) begin
            errors++;
            $display("FAIL tick_count: got %0d required 61", ticks_seen);
        end
        for (int s = 2; s <= 59; s++) expect_tick(tod(0, 1, s));
        step(232);
        run_en = 0;
        pulse_min(58);
        pulse_hr(23);
        snap("preload", tod(23, 59, 59), 0, 1);
        run_en = 1;
        expect_tick(tod(0, 0, 0));
        step(4);
        snap("day_wrap", tod(0, 0, 0), 1, 1);
        run_en = 0;
        pulse_hr(12);
        pulse_min(34);
        snap("t3_pre", tod(12, 34, 0), 0, 1);
        for (int s = 1; s <= 59; s++) expect_tick(tod(12, 34, s));
        run_en = 1;
        step(239);
        inc_min = 1; step(1); inc_min = 0;
        snap("defer_edit", tod(12, 35, 59), 0, 1);
        expect_tick(tod(12, 36, 0));
        step(1);
        snap("deferred_tick", tod(12, 36, 0), 1, 1);
        run_en = 0;
        step(1);
        pulse_hr(11);
        snap("hr23", tod(23, 36, 0), 0, 1);
        pulse_hr(1);
        snap("hr_wrap", tod(0, 36, 0), 0, 1);
        pulse_min(23);
        for (int s = 1; s <= 30; s++) expect_tick(tod(0, 59, s));
        run_en = 1;
        step(120);
        run_en = 0;
        pulse_min(1);
        snap("min_wrap", tod(0, 0, 30), 0, 1);
        inc_hr = 1; inc_min = 1; step(1); inc_hr = 0; inc_min = 0;
        snap("both_edits", tod(1, 1, 30), 0, 1);
        step(20);
        snap("frozen", tod(1, 1, 30), 0, 1);
        run_en = 1;
        expect_tick(tod(1, 1, 31));
        step(3);
        snap("reen_wait", tod(1, 1, 30), 0, 0);
        step(1);
        snap("reen_tick", tod(1, 1, 31), 1, 1);
        run_en = 0;
        step(1);
        pulse_hr(5);
        pulse_min(7);
        for (int s = 32; s <= 42; s++) expect_tick(tod(6, 8, s));
        run_en = 1;
        step(47);
        inc_hr = 1; step(1); inc_hr = 0;
        snap("pend_edit", tod(7, 8, 42), 0, 1);
        clr_sec = 1; step(1); clr_sec = 0;
        snap("clr_pending", tod(7, 8, 0), 0, 1);
        expect_tick(tod(7, 8, 1));
        step(3);
        snap("post_clr_wait", tod(7, 8, 0), 0, 0);
        step(1);
        snap("post_clr_tick", tod(7, 8, 1), 1, 1);
        step(2);
        rst = 1; #1;
        snap("async_rst", tod(0, 0, 0), 0, 1);
        step(2);
        rst = 0;
        @(negedge clk); #1;
        checks++;
        if (tick_q.size() != 0) begin
            errors++;
            $display("FAIL ticks_outstanding: got %0d unconsumed required 0", tick_q.size());
        end
        checks++;
        if (ticks_seen != ticks_pushed) begin
            errors++;
            $display("FAIL tick_total: got %0d required %0d", ticks_seen, ticks_pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
